act_share_sched: RTL and testbench
==================================

Name: act_share_sched

Overview:
- Round-robin scheduler that shares one combinational Q8.8 sigmoid activation unit among NUM_REQ neuron requesters.
- Each requester hands over a 16-bit signed Q8.8 pre-activation using a valid/ready handshake.
- The scheduler drives the shared unit's input from a register and captures the unit's output one cycle later.
- It returns the result with the requester ID on a single valid/ready response channel. It sits between the neuron accumulators and the activation unit.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
ID_W, 2, width of rsp_id; must satisfy 2**ID_W >= NUM_REQ

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester valid
req_data  in  16*NUM_REQ  Q8.8 signed pre-activations; requester i uses bits [16i+15:16i]
req_ready  out  NUM_REQ  one-hot grant/accept strobe
act_in  out  16  registered operand to the shared activation unit
act_out  in  16  result from the shared activation unit (combinational from act_in)
rsp_valid  out  1  result valid
rsp_data  out  16  Q8.8 activation result, 0x0000..0x0100
rsp_id  out  ID_W  index of the requester that owns rsp_data
rsp_ready  in  1  downstream accept
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst_n=0) forces all of the following:
  - state=IDLE, rr_ptr=0;
  - req_ready=0, act_in=0x0000;
  - rsp_valid=0, rsp_data=0x0000, rsp_id=0, busy=0.
- FSM states: IDLE, EVAL, RESP.
- IDLE:
  - If any req_valid is high, grant the first valid index at or after rr_ptr, searching upward and wrapping to 0.
  - The grant is a combinational req_ready pulse for the granted index only, lasting exactly one cycle, and only while in IDLE.
  - On that edge: act_in<=req_data[g], id_reg<=g, rr_ptr<=(g+1) mod NUM_REQ, state->EVAL.
- EVAL (one cycle): rsp_data<=act_out, rsp_id<=id_reg, rsp_valid<=1, state->RESP.
- RESP:
  - Hold rsp_valid, rsp_data and rsp_id stable until rsp_ready=1.
  - On an edge with rsp_valid&rsp_ready: rsp_valid<=0, state->IDLE.
  - No new grant is issued in the same cycle as the response handshake.
- Throughput and latency:
  - One result per 3 cycles with rsp_ready tied high.
  - Latency from req_valid&req_ready to rsp_valid: 2 cycles.
- req_ready is never asserted outside IDLE.
- Requesters must hold req_data stable while req_valid=1. Deasserting req_valid before the grant is legal; the request is simply not taken.
- Fairness:
  - A requester that holds valid is granted within NUM_REQ grants.
  - rr_ptr advances only on a grant.
- act_out is sampled only in EVAL. act_in stays at the last granted operand between grants.
- rst_n asserted mid-operation aborts any transaction and discards any pending response. The first grant after reset goes to the lowest valid index.
- NUM_REQ not a power of two: rr_ptr wraps at NUM_REQ; unused ID codes are never produced.

Optional Feature:
Macro: ACT_SAT_STATS_EN
- Defined:
  - Adds input stats_clr (1b) and outputs sat_hi_cnt, sat_lo_cnt (16b each).
  - On each grant, a signed operand > 0x0600 increments sat_hi_cnt; an operand < 0xFA00 increments sat_lo_cnt.
  - Both counters saturate at 0xFFFF.
  - stats_clr=1 synchronously zeroes both counters and takes priority over an increment in the same cycle.
  - Reset zeroes both counters.
- Undefined: the ports and counters are absent, and scheduling behaviour is identical.

Test Plan:
- Single request: req_valid[0]=1, req_data[0]=0x0000, rsp_ready=1 -> req_ready=0001 for 1 cycle; 2 cycles later rsp_valid=1, rsp_data=0x0080, rsp_id=0.
- Saturation: req_data[2]=0x0700 -> rsp_data=0x0100, rsp_id=2. Then req_data[2]=0xF000 -> rsp_data=0x0000. With ACT_SAT_STATS_EN: sat_hi_cnt=1, sat_lo_cnt=1.
- Round-robin: all four req_valid held high, rsp_ready=1 -> grant order 0,1,2,3,0, and rsp_id follows the same sequence.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_data/rsp_id stable, req_ready stays 0 for all requesters. rsp_ready=1 -> handshake, IDLE next cycle, next grant one cycle later.
- Reset mid-transaction: drop rst_n while in EVAL -> rsp_valid=0, busy=0 immediately. After release with req_valid=1010, the first grant goes to index 1.
- Stats clear collision (ACT_SAT_STATS_EN): stats_clr=1 in the same cycle as a grant of 0x0601 -> sat_hi_cnt=0 after the edge.

Source files
------------

// File: rtl/act_share_sched.sv
// Round-robin scheduler sharing one combinational Q8.8 sigmoid unit among NUM_REQ requesters.
// Optional saturation statistics are enabled by defining ACT_SAT_STATS_EN.
module act_share_sched #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [16*NUM_REQ-1:0]  req_data,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [15:0]            act_in,
    input  logic [15:0]            act_out,
    output logic                   rsp_valid,
    output logic [15:0]            rsp_data,
    output logic [ID_W-1:0]        rsp_id,
    input  logic                   rsp_ready,
`ifdef ACT_SAT_STATS_EN
    input  logic                   stats_clr,
    output logic [15:0]            sat_hi_cnt,
    output logic [15:0]            sat_lo_cnt,
`endif
    output logic                   busy
);

    typedef enum logic [1:0] {StIdle, StEval, StResp} state_e;

    state_e          state_q, state_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0] id_q;
    logic [ID_W-1:0] gnt_idx, hi_idx, lo_idx;
    logic            gnt_found, hi_found;
    logic [15:0]     gnt_data;
    logic            take;

    // Descending scan so the last hit is the lowest index; hi_* only counts indices >= rr_ptr.
    always_comb begin
        hi_found  = 1'b0;
        gnt_found = 1'b0;
        hi_idx    = '0;
        lo_idx    = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                gnt_found = 1'b1;
                lo_idx    = ID_W'(i);
                if (ID_W'(i) >= rr_ptr_q) begin
                    hi_found = 1'b1;
                    hi_idx   = ID_W'(i);
                end
            end
        end
        gnt_idx = hi_found ? hi_idx : lo_idx;
    end

    always_comb begin
        gnt_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_idx == ID_W'(i)) gnt_data = req_data[16*i +: 16];
        end
    end

    assign take     = (state_q == StIdle) && gnt_found;
    assign rr_ptr_d = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;

    // Gated by rst_n so the grant strobe is quiet while reset is held.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = rst_n && take && (gnt_idx == ID_W'(i));
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (gnt_found) state_d = StEval;
            StEval:  state_d = StResp;
            StResp:  if (rsp_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign busy = (state_q != StIdle);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            rr_ptr_q  <= '0;
            id_q      <= '0;
            act_in    <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= '0;
        end else begin
            state_q <= state_d;
            if (take) begin
                act_in   <= gnt_data;
                id_q     <= gnt_idx;
                rr_ptr_q <= rr_ptr_d;
            end
            if (state_q == StEval) begin
                rsp_data  <= act_out;
                rsp_id    <= id_q;
                rsp_valid <= 1'b1;
            end else if ((state_q == StResp) && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

`ifdef ACT_SAT_STATS_EN
    logic op_hi, op_lo;
    assign op_hi = $signed(gnt_data) > $signed(16'h0600);
    assign op_lo = $signed(gnt_data) < $signed(16'hFA00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_hi_cnt <= '0;
            sat_lo_cnt <= '0;
        end else if (stats_clr) begin
            sat_hi_cnt <= '0;
            sat_lo_cnt <= '0;
        end else if (take) begin
            if (op_hi && (sat_hi_cnt != 16'hFFFF)) sat_hi_cnt <= sat_hi_cnt + 16'd1;
            if (op_lo && (sat_lo_cnt != 16'hFFFF)) sat_lo_cnt <= sat_lo_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_act_share_sched.sv
// Directed bench for act_share_sched; a hard-sigmoid model stands in for the activation unit.
module tb_act_share_sched;

    localparam int NumReq = 4;
    localparam int IdW    = 2;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NumReq-1:0]     req_valid;
    logic [16*NumReq-1:0]  req_data;
    logic [NumReq-1:0]     req_ready;
    logic [15:0]           act_in, act_out, rsp_data;
    logic                  rsp_valid, rsp_ready, busy;
    logic [IdW-1:0]        rsp_id;
`ifdef ACT_SAT_STATS_EN
    logic                  stats_clr;
    logic [15:0]           sat_hi_cnt, sat_lo_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic [IdW-1:0] id;
        logic [15:0]    data;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    // y = clamp(0.5 + x/4, 0, 1) in Q8.8
    function automatic logic [15:0] sig_model(input logic [15:0] x);
        int v;
        v = 128 + (int'($signed(x)) >>> 2);
        if (v < 0) v = 0;
        if (v > 256) v = 256;
        return 16'(v);
    endfunction

    assign act_out = sig_model(act_in);

    act_share_sched #(.NUM_REQ(NumReq), .ID_W(IdW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .act_in    (act_in),
        .act_out   (act_out),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .rsp_ready (rsp_ready),
`ifdef ACT_SAT_STATS_EN
        .stats_clr (stats_clr),
        .sat_hi_cnt(sat_hi_cnt),
        .sat_lo_cnt(sat_lo_cnt),
`endif
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input int idx, input logic [15:0] data);
        exp_t e;
        e.id   = IdW'(idx);
        e.data = sig_model(data);
        sb.push_back(e);
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rsp_data"}, 32'(rsp_data), 32'd0);
        chk({tag, "_rsp_id"}, 32'(rsp_id), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        chk({tag, "_act_in"}, 32'(act_in), 32'd0);
    endtask

    // Called one cycle after a grant; returns cycles from grant to rsp_valid.
    task automatic wait_rsp(input string tag, output int lat);
        exp_t e;
        lat = 1;
        while (!rsp_valid && lat < 8) begin
            @(negedge clk); #1;
            lat++;
        end
        chk({tag, "_valid"}, 32'(rsp_valid), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_data"}, 32'(rsp_data), 32'(e.data));
            chk({tag, "_id"}, 32'(rsp_id), 32'(e.id));
        end else begin
            chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
        end
    endtask

    task automatic one_shot(input string tag, input int idx, input logic [15:0] data);
        int lat;
        @(negedge clk);
        req_valid[idx]          = 1'b1;
        req_data[16*idx +: 16]  = data;
        push_exp(idx, data);
        #1;
        chk({tag, "_grant"}, 32'(req_ready), 32'd1 << idx);
        @(negedge clk);
        req_valid[idx] = 1'b0;
        #1;
        chk({tag, "_pulse"}, 32'(req_ready), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        wait_rsp(tag, lat);
        chk({tag, "_lat"}, 32'(lat), 32'd2);
        chk({tag, "_act_in"}, 32'(act_in), 32'(data));
    endtask

    initial begin
        int lat;
        exp_t  hold;
        logic [15:0] rr_data [NumReq];
        rr_data[0] = 16'h0040;
        rr_data[1] = 16'hFFC0;
        rr_data[2] = 16'h0180;
        rr_data[3] = 16'hFE80;

        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        rsp_ready = 1'b1;
`ifdef ACT_SAT_STATS_EN
        stats_clr = 1'b0;
`endif
        repeat (2) @(negedge clk);
        #1;
        reset_checks("reset");
        @(negedge clk);
        rst_n = 1'b1;

        one_shot("single", 0, 16'h0000);
        one_shot("hi_edge", 0, 16'h0600);
        one_shot("lo_edge", 1, 16'hFA00);
        one_shot("sat_hi", 2, 16'h0700);
        one_shot("sat_lo", 2, 16'hF000);
        one_shot("mid_pos", 3, 16'h0100);
        one_shot("mid_neg", 1, 16'hFF00);
`ifdef ACT_SAT_STATS_EN
        chk("sat_hi_cnt", 32'(sat_hi_cnt), 32'd1);
        chk("sat_lo_cnt", 32'(sat_lo_cnt), 32'd1);
        @(negedge clk);
        stats_clr         = 1'b1;
        req_valid[2]      = 1'b1;
        req_data[32 +: 16] = 16'h0601;
        push_exp(2, 16'h0601);
        #1;
        chk("clr_grant", 32'(req_ready), 32'b0100);
        @(negedge clk);
        stats_clr    = 1'b0;
        req_valid[2] = 1'b0;
        #1;
        chk("clr_hi_cnt", 32'(sat_hi_cnt), 32'd0);
        chk("clr_lo_cnt", 32'(sat_lo_cnt), 32'd0);
        wait_rsp("clr", lat);
`endif

        // Reset pulse so round-robin starts from pointer 0.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        reset_checks("rst_pulse");
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < 5; k++) push_exp(k % NumReq, rr_data[k % NumReq]);
        @(negedge clk);
        for (int i = 0; i < NumReq; i++) req_data[16*i +: 16] = rr_data[i];
        req_valid = '1;
        #1;
        for (int k = 0; k < 5; k++) begin
            int n = 0;
            while (req_ready == '0 && n < 4) begin
                @(negedge clk); #1;
                n++;
            end
            chk("rr_grant", 32'(req_ready), 32'd1 << (k % NumReq));
            chk("rr_gap", 32'(n), 32'd0);
            @(negedge clk); #1;
            wait_rsp("rr", lat);
            if (k == 4) req_valid = '0;
            @(negedge clk); #1;
        end

        // Backpressure with requester 3 waiting throughout.
        req_valid[1]       = 1'b1;
        req_data[16 +: 16] = 16'h0123;
        rsp_ready          = 1'b0;
        push_exp(1, 16'h0123);
        #1;
        chk("bp_grant", 32'(req_ready), 32'b0010);
        @(negedge clk);
        req_valid[1]       = 1'b0;
        req_valid[3]       = 1'b1;
        req_data[48 +: 16] = 16'h0300;
        #1;
        chk("bp_eval_ready", 32'(req_ready), 32'd0);
        @(negedge clk); #1;
        chk("bp_valid", 32'(rsp_valid), 32'd1);
        hold = sb[0];
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); #1;
            chk("bp_hold_valid", 32'(rsp_valid), 32'd1);
            chk("bp_hold_data", 32'(rsp_data), 32'(hold.data));
            chk("bp_hold_id", 32'(rsp_id), 32'(hold.id));
            chk("bp_hold_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        wait_rsp("bp", lat);
        @(negedge clk); #1;
        chk("bp_idle_busy", 32'(busy), 32'd0);
        chk("bp_idle_valid", 32'(rsp_valid), 32'd0);
        chk("bp_next_grant", 32'(req_ready), 32'b1000);
        push_exp(3, 16'h0300);
        @(negedge clk);
        req_valid[3] = 1'b0;
        #1;
        wait_rsp("bp_next", lat);

        // Reset while in EVAL; the pending response is dropped.
        @(negedge clk);
        req_valid[2]       = 1'b1;
        req_data[32 +: 16] = 16'h0050;
        #1;
        chk("mid_grant", 32'(req_ready), 32'b0100);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_ready", 32'(req_ready), 32'd0);
        sb.delete();
        req_valid          = 4'b1010;
        req_data[16 +: 16] = 16'h00A0;
        req_data[48 +: 16] = 16'hFF60;
        @(negedge clk);
        rst_n = 1'b1;
        push_exp(1, 16'h00A0);
        #1;
        chk("mid_first_grant", 32'(req_ready), 32'b0010);
        @(negedge clk);
        req_valid = '0;
        #1;
        wait_rsp("mid_after", lat);
        chk("mid_after_lat", 32'(lat), 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
